// File: rtl/pcs_link_pkg.sv
// Shared link definitions: 10b control symbol encodings and the scheduler state type.
package pcs_link_pkg;

   localparam int SYM_W = 10;

   localparam logic [SYM_W-1:0] COMMA_SYM = 10'b1100000101;
   localparam logic [SYM_W-1:0] SOF_SYM   = 10'b1101101000;
   localparam logic [SYM_W-1:0] EOF_SYM   = 10'b1011101000;
   localparam logic [SYM_W-1:0] FILL_SYM  = 10'b1110101000;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      EOF
   } state_t;

endpackage

// File: rtl/pcs_tx_scheduler_if.sv
// Source/serializer handshake bundle of pcs_tx_scheduler; slave is the scheduler side.
interface pcs_tx_scheduler_if #(
   parameter int NUM_REQ = 2
);
   import pcs_link_pkg::*;

   localparam int GW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req_valid;
   logic [SYM_W*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]       req_last;
   logic [NUM_REQ-1:0]       req_ready;
   logic [SYM_W-1:0]         sym_out;
   logic                     sym_empty;
   logic                     sym_rd_en;
   logic [GW-1:0]            grant_id;
   logic                     busy;
   logic                     underrun;

   modport master (
      output req_valid, req_data, req_last, sym_rd_en,
      input  req_ready, sym_out, sym_empty, grant_id, busy, underrun
   );

   modport slave (
      input  req_valid, req_data, req_last, sym_rd_en,
      output req_ready, sym_out, sym_empty, grant_id, busy, underrun
   );

endinterface

// File: rtl/pcs_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, as one-hot and index.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         grant_o,
   output logic [$clog2(N)-1:0] idx_o
);

   localparam int IW = $clog2(N);

   logic          found;
   logic [IW-1:0] pos;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      pos     = '0;
      for (int k = 0; k < N; k++) begin
         pos = IW'((int'(ptr_i) + k) % N);
         if (!found && req_i[pos]) begin
            found        = 1'b1;
            grant_o[pos] = 1'b1;
            idx_o        = pos;
         end
      end
   end

endmodule

// File: rtl/pcs_tx_scheduler.sv
// Round-robin packet scheduler feeding a one-symbol FWFT slot for serializer_10b.
// Optional feature macro: COMMA_SCHED_EN (periodic comma insertion between packets).
module pcs_tx_scheduler
   import pcs_link_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int COMMA_INTERVAL = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   pcs_tx_scheduler_if.slave bus
);

   localparam int GW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || COMMA_INTERVAL < 4) begin : g_param_check
      $error("pcs_tx_scheduler: unsupported NUM_REQ or COMMA_INTERVAL");
   end

   state_t             state_q, state_d;
   logic               out_vld_q, out_vld_d;
   logic [SYM_W-1:0]   sym_q, sym_d;
   logic [GW-1:0]      grant_q, grant_d;
   logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
   logic               underrun_q, underrun_d;

   logic               pop, slot_free, any_req, comma_due;
   logic               cur_valid, cur_last;
   logic [SYM_W-1:0]   cur_data;
   logic [GW-1:0]      rr_next;
   logic [NUM_REQ-1:0] arb_grant;
   logic [GW-1:0]      arb_idx;
   logic               load, load_fill;
   logic [SYM_W-1:0]   load_sym;
   logic [NUM_REQ-1:0] ready;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req_i   (bus.req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (arb_grant),
      .idx_o   (arb_idx)
   );

   // The slot can take a new symbol when empty or when it is being popped this cycle.
   assign pop       = bus.sym_rd_en & out_vld_q;
   assign slot_free = !out_vld_q | bus.sym_rd_en;
   assign any_req   = |arb_grant;
   assign cur_valid = bus.req_valid[grant_q];
   assign cur_last  = bus.req_last[grant_q];
   assign cur_data  = bus.req_data[int'(grant_q)*SYM_W +: SYM_W];
   assign rr_next   = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef COMMA_SCHED_EN
   localparam int CW = $clog2(COMMA_INTERVAL + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign comma_due = (cnt_q >= CW'(COMMA_INTERVAL));

   // A scheduled comma restarts the count even if a symbol is popped the same cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE && slot_free && comma_due) begin
         cnt_d = '0;
      end else if (pop && cnt_q != CW'(COMMA_INTERVAL)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign comma_due = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         out_vld_q  <= 1'b0;
         sym_q      <= COMMA_SYM;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_vld_q  <= out_vld_d;
         sym_q      <= sym_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         underrun_q <= underrun_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (slot_free && !comma_due && any_req) state_d = DATA;
         DATA:    if (slot_free && cur_valid && cur_last) state_d = EOF;
         EOF:     if (slot_free) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      load      = 1'b0;
      load_fill = 1'b0;
      load_sym  = COMMA_SYM;
      ready     = '0;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (slot_free && comma_due) begin
               load     = 1'b1;
               load_sym = COMMA_SYM;
            end else if (slot_free && any_req) begin
               load     = 1'b1;
               load_sym = SOF_SYM;
               grant_d  = arb_idx;
            end
         end
         DATA: begin
            if (slot_free) begin
               load = 1'b1;
               if (cur_valid) begin
                  ready[grant_q] = 1'b1;
                  load_sym       = cur_data;
               end else begin
                  load_sym  = FILL_SYM;
                  load_fill = 1'b1;
               end
            end
         end
         EOF: begin
            if (slot_free) begin
               load     = 1'b1;
               load_sym = EOF_SYM;
               rr_ptr_d = rr_next;
            end
         end
         default: ;
      endcase
   end

   // An emptied slot shows a comma so sym_out never carries a stale data symbol.
   always_comb begin
      out_vld_d  = out_vld_q;
      sym_d      = sym_q;
      underrun_d = load_fill;
      if (load) begin
         out_vld_d = 1'b1;
         sym_d     = load_sym;
      end else if (pop) begin
         out_vld_d = 1'b0;
         sym_d     = COMMA_SYM;
      end
   end

   assign bus.req_ready = ready;
   assign bus.sym_out   = sym_q;
   assign bus.sym_empty = !out_vld_q;
   assign bus.grant_id  = grant_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_pcs_tx_scheduler.sv
// Bench for pcs_tx_scheduler: directed packets plus randomized traffic checked by a packet-level model.
// Build with COMMA_SCHED_EN defined to also exercise scheduled comma insertion.
module tb_pcs_tx_scheduler;

   localparam int NUM_REQ = 3;
`ifdef COMMA_SCHED_EN
   localparam int COMMA_INTERVAL = 8;
   localparam int COMMA_BOUND    = COMMA_INTERVAL + 24;
`else
   localparam int COMMA_INTERVAL = 64;
`endif

   localparam logic [9:0] COMMA_S = 10'b1100000101;
   localparam logic [9:0] SOF_S   = 10'b1101101000;
   localparam logic [9:0] EOF_S   = 10'b1011101000;
   localparam logic [9:0] FILL_S  = 10'b1110101000;

   typedef struct packed {
      logic [7:0] gap;
      logic       last;
      logic [9:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   pcs_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

   pcs_tx_scheduler #(.NUM_REQ(NUM_REQ), .COMMA_INTERVAL(COMMA_INTERVAL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Per-source driver queues (what the source presents) and model queues (what must come out).
   ent_t       drvQ[NUM_REQ][$];
   ent_t       expQ[NUM_REQ][$];
   logic [9:0] obsLog[$];
   logic [9:0] expS[$];
   int         sofLog[$];

   int checks = 0;
   int errors = 0;
   int fillSeen, underrunSeen, commaSeen, sinceComma, rrPtr, curSrc, rdProb;
   bit inPkt, expectEof;

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] randPayload();
      logic [9:0] d;
      do d = 10'($urandom_range(0, 1023));
      while (d == COMMA_S || d == SOF_S || d == EOF_S || d == FILL_S);
      return d;
   endfunction

   task automatic addEntry(input int src, input logic [9:0] d, input logic last, input int gap);
      ent_t e;
      e.gap  = 8'(gap);
      e.last = last;
      e.data = d;
      drvQ[src].push_back(e);
      expQ[src].push_back(e);
   endtask

   task automatic addPacket(input int src, input int len, input bit gaps);
      for (int k = 0; k < len; k++) begin
         addEntry(src, randPayload(), k == len - 1, (gaps && k > 0) ? int'($urandom_range(0, 2)) : 0);
      end
   endtask

   task automatic clearModel();
      for (int i = 0; i < NUM_REQ; i++) begin
         drvQ[i].delete();
         expQ[i].delete();
      end
      obsLog.delete();
      sofLog.delete();
      fillSeen     = 0;
      underrunSeen = 0;
      commaSeen    = 0;
      sinceComma   = 0;
      rrPtr        = 0;
      inPkt        = 1'b0;
      expectEof    = 1'b0;
   endtask

   function automatic bit pending();
      for (int i = 0; i < NUM_REQ; i++) if (expQ[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   // Round-robin rule: the first source at/after the pointer that still owes a packet.
   function automatic int nextSrc();
      for (int k = 0; k < NUM_REQ; k++) begin
         if (expQ[(rrPtr + k) % NUM_REQ].size() > 0) return (rrPtr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   // Packet-level scoreboard fed with every symbol the serializer pops.
   task automatic scoreSymbol(input logic [9:0] sym);
      int   s;
      ent_t e;
      obsLog.push_back(sym);
`ifdef COMMA_SCHED_EN
      if (sym == COMMA_S && !inPkt) begin
         commaSeen++;
         sinceComma = 0;
         return;
      end
      sinceComma++;
      checkOutput("comma_spacing", sinceComma <= COMMA_BOUND, 1'b1);
`endif
      if (!inPkt) begin
         s = nextSrc();
         checkOutput("sof", sym, SOF_S);
         checkOutput("packet_pending", s >= 0, 1'b1);
         if (s >= 0) begin
            checkOutput("grant_id", bus.grant_id, 16'(s));
            checkOutput("busy_in_pkt", bus.busy, 1'b1);
            inPkt     = 1'b1;
            expectEof = 1'b0;
            curSrc    = s;
            sofLog.push_back(s);
         end
      end else if (expectEof) begin
         checkOutput("eof", sym, EOF_S);
         checkOutput("busy_after_eof", bus.busy, 1'b0);
         inPkt = 1'b0;
         rrPtr = (curSrc + 1) % NUM_REQ;
      end else if (sym == FILL_S) begin
         fillSeen++;
      end else if (expQ[curSrc].size() == 0) begin
         checkOutput("payload_underflow", sym, 16'hFFFF);
      end else begin
         e = expQ[curSrc].pop_front();
         checkOutput("payload", sym, e.data);
         expectEof = e.last;
      end
   endtask

   // One clock: drive sources and serializer at the falling edge, then observe handshakes.
   task automatic applyStimulus();
      logic [NUM_REQ-1:0]    v, l;
      logic [10*NUM_REQ-1:0] d;
      ent_t                  e;
      logic [NUM_REQ-1:0]    rdy;
      @(negedge clk);
      if (bus.underrun === 1'b1) underrunSeen++;
      v = '0;
      l = '0;
      d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (drvQ[i].size() > 0) begin
            e = drvQ[i][0];
            if (e.gap != 8'd0) begin
               e.gap      = e.gap - 8'd1;
               drvQ[i][0] = e;
            end else begin
               v[i]           = 1'b1;
               l[i]           = e.last;
               d[i*10 +: 10]  = e.data;
            end
         end
      end
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = d;
      bus.sym_rd_en = (int'($urandom_range(0, 99)) < rdProb);
      #1;
      rdy = bus.req_ready;
      checkOutput("req_ready_scope",
                  ($countones(rdy) <= 1) && (bus.busy || rdy == '0) && (rdy == '0 || rdy[bus.grant_id]),
                  1'b1);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (v[i] && rdy[i]) void'(drvQ[i].pop_front());
      end
      if (bus.sym_rd_en && !bus.sym_empty) scoreSymbol(bus.sym_out);
   endtask

   task automatic runUntilDrained(input int maxCycles, input string tag);
      int n = 0;
      while ((pending() || inPkt) && n < maxCycles) begin
         applyStimulus();
         n++;
      end
      checkOutput({tag, "_drained"}, pending() || inPkt, 1'b0);
   endtask

   task automatic compareStream(input string tag);
      checkOutput({tag, "_len"}, 16'(obsLog.size()), 16'(expS.size()));
      for (int k = 0; k < expS.size() && k < obsLog.size(); k++) begin
         checkOutput({tag, "_sym"}, obsLog[k], expS[k]);
      end
   endtask

   task automatic resetDut();
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      bus.sym_rd_en = 1'b0;
      clearModel();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus.sym_rd_en = k[0];
      end
      #1;
      checkOutput("rst_sym_empty", bus.sym_empty, 1'b1);
      checkOutput("rst_sym_out", bus.sym_out, COMMA_S);
      checkOutput("rst_req_ready", 16'(bus.req_ready), 16'h0);
      checkOutput("rst_busy", bus.busy, 1'b0);
      checkOutput("rst_grant_id", 16'(bus.grant_id), 16'h0);
      checkOutput("rst_underrun", bus.underrun, 1'b0);
      @(negedge clk);
      bus.sym_rd_en = 1'b0;
      rst_n         = 1'b1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [9:0] a, b;

      // Idle link: popping an empty slot changes nothing.
      resetDut();
      rdProb = 50;
      repeat (8) applyStimulus();
      checkOutput("idle_empty", bus.sym_empty, 1'b1);
      checkOutput("idle_busy", bus.busy, 1'b0);
      checkOutput("idle_no_pops", 16'(obsLog.size()), 16'h0);

      // Single three-symbol packet from source 0.
      resetDut();
      rdProb = 100;
      addEntry(0, 10'h155, 1'b0, 0);
      addEntry(0, 10'h2AA, 1'b0, 0);
      addEntry(0, 10'h0F0, 1'b1, 0);
      runUntilDrained(50, "t2");
      expS = '{SOF_S, 10'h155, 10'h2AA, 10'h0F0, EOF_S};
      compareStream("t2");
      checkOutput("t2_underrun", 16'(underrunSeen), 16'h0);

      // Two sources competing from reset: 0, 1, 0.
      resetDut();
      rdProb = 100;
      addPacket(0, 3, 1'b0);
      addPacket(1, 3, 1'b0);
      addPacket(0, 3, 1'b0);
      runUntilDrained(100, "t3");
      checkOutput("t3_pkts", 16'(sofLog.size()), 16'd3);
      if (sofLog.size() == 3) begin
         checkOutput("t3_order0", 16'(sofLog[0]), 16'd0);
         checkOutput("t3_order1", 16'(sofLog[1]), 16'd1);
         checkOutput("t3_order2", 16'(sofLog[2]), 16'd0);
      end

      // Source stalls two cycles mid-packet: two FILLs, two underrun pulses.
      resetDut();
      rdProb = 100;
      a = randPayload();
      b = randPayload();
      addEntry(0, 10'h011, 1'b0, 0);
      addEntry(0, a, 1'b0, 2);
      addEntry(0, b, 1'b1, 0);
      runUntilDrained(50, "t4");
      expS = '{SOF_S, 10'h011, FILL_S, FILL_S, a, b, EOF_S};
      compareStream("t4");
      checkOutput("t4_fills", 16'(fillSeen), 16'd2);
      checkOutput("t4_underrun", 16'(underrunSeen), 16'd2);

`ifdef COMMA_SCHED_EN
      // Back-to-back 6-symbol packets: comma lands after the EOF that crosses the interval.
      resetDut();
      rdProb = 100;
      for (int p = 0; p < 4; p++) begin
         addPacket(0, 4, 1'b0);
         addPacket(1, 4, 1'b0);
      end
      runUntilDrained(400, "t5");
      checkOutput("t5_comma_seen", commaSeen > 0, 1'b1);
      if (obsLog.size() > 12) checkOutput("t5_comma_pos", obsLog[12], COMMA_S);
      else checkOutput("t5_stream_len", obsLog.size() > 12, 1'b1);
`endif

      // Asynchronous reset in the middle of a payload.
      resetDut();
      rdProb = 100;
      addPacket(0, 6, 1'b0);
      repeat (4) applyStimulus();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_empty_async", bus.sym_empty, 1'b1);
      checkOutput("t6_busy_async", bus.busy, 1'b0);
      checkOutput("t6_ready_async", 16'(bus.req_ready), 16'h0);
      clearModel();
      bus.req_valid = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      a = randPayload();
      b = randPayload();
      addEntry(1, a, 1'b0, 0);
      addEntry(1, b, 1'b1, 0);
      runUntilDrained(50, "t6");
      expS = '{SOF_S, a, b, EOF_S};
      compareStream("t6");

      // Randomized traffic with source stalls and serializer back-pressure.
      resetDut();
      for (int r = 0; r < 2; r++) begin
         rdProb = (r == 0) ? 75 : 40;
         for (int p = 0; p < 4; p++) begin
            for (int s = 0; s < NUM_REQ; s++) addPacket(s, int'($urandom_range(1, 6)), 1'b1);
         end
         runUntilDrained(4000, "rand");
         checkOutput("rand_underrun_vs_fill", 16'(underrunSeen), 16'(fillSeen));
         checkOutput("rand_idle_busy", bus.busy, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
